// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan path.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Picks nibble idx out of a frame zero-extended to the widest supported display.
    function automatic logic [NIBBLE_W-1:0] nibble_sel(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] frame,
        input logic [2:0]                     idx
    );
        return frame[{idx, 2'b00} +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing one scan tick every TICK_DIV cycles while run is high.
module scan_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        run,
    output logic                        tick,
    output logic [$clog2(TICK_DIV)-1:0] count
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Digit-scan sequencer for a multiplexed 7-segment display with blanking between digits.
// Optional dimming via BRIGHTNESS_EN (adds the brightness[2:0] input).
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1000,
    parameter int BLANK_TICKS = 1,
    parameter int ON_TICKS    = 3,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in,
    input  logic                           load,
`ifdef BRIGHTNESS_EN
    input  logic [2:0]                     brightness,
`endif
    output logic                           load_ack,
    output logic [NUM_DIGITS-1:0]          anode,
    output logic [NIBBLE_W-1:0]            char,
    output logic [IDX_W-1:0]               digit_idx,
    output logic                           frame_start
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int TMAX   = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int TCNT_W = $clog2(TMAX + 1);

    localparam logic [TCNT_W-1:0]     BLANK_LAST = TCNT_W'(BLANK_TICKS - 1);
    localparam logic [TCNT_W-1:0]     ON_LAST    = TCNT_W'(ON_TICKS - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] OFF        = ANODE_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

    scan_state_t                    state;
    logic [NIBBLE_W*NUM_DIGITS-1:0] shadow;
    logic [TCNT_W-1:0]              tick_cnt;
    logic [NUM_DIGITS-1:0]          anode_q;
    logic [NIBBLE_W*MAX_DIGITS-1:0] frame_ext;
    logic [NUM_DIGITS-1:0]          sel_mask;
    logic                           tick;
    logic [CNT_W-1:0]               count;
    logic [2:0]                     bright_q;
    logic                           dim_on;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .run     (state != IDLE),
        .tick    (tick),
        .count   (count)
    );

    assign frame_ext = (NIBBLE_W*MAX_DIGITS)'(shadow);
    assign sel_mask  = ~(ONE_HOT0 << digit_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            anode_q     <= OFF;
            char        <= '0;
            digit_idx   <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            shadow      <= '0;
            tick_cnt    <= '0;
        end else begin
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                anode_q   <= OFF;
                digit_idx <= '0;
                tick_cnt  <= '0;
                if (state == IDLE && load && !load_ack) begin
                    shadow   <= data_in;
                    load_ack <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        // Gating on load_ack keeps the ack a single-cycle pulse.
                        if (load && !load_ack) begin
                            shadow   <= data_in;
                            load_ack <= 1'b1;
                        end
                        state       <= BLANK;
                        digit_idx   <= '0;
                        tick_cnt    <= '0;
                        frame_start <= 1'b1;
                    end
                    BLANK: begin
                        if (tick) begin
                            if (tick_cnt == BLANK_LAST) begin
                                tick_cnt <= '0;
                                char     <= nibble_sel(frame_ext, 3'(digit_idx));
                                anode_q  <= sel_mask;
                                state    <= DRIVE;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    DRIVE: begin
                        if (tick) begin
                            if (tick_cnt == ON_LAST) begin
                                tick_cnt <= '0;
                                anode_q  <= OFF;
                                state    <= BLANK;
                                // Shadow only changes at the frame wrap so a frame never mixes data.
                                if (digit_idx == LAST_IDX) begin
                                    digit_idx   <= '0;
                                    frame_start <= 1'b1;
                                    if (load) begin
                                        shadow   <= data_in;
                                        load_ack <= 1'b1;
                                    end
                                end else begin
                                    digit_idx <= digit_idx + 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BRIGHTNESS_EN
    // Level is sampled only at a prescaler wrap so a PWM period is never cut short.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= 3'd7;
        end else if (state == IDLE || tick) begin
            bright_q <= brightness;
        end
    end
`else
    assign bright_q = 3'd7;
`endif

    // Full brightness makes the threshold TICK_DIV, so the digit stays on for the whole DRIVE.
    assign dim_on = int'(count) < (((int'(bright_q) + 1) * TICK_DIV) / 8);
    assign anode  = (state == DRIVE && !dim_on) ? OFF : anode_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed and invariant-checking bench for seven_seg_scan_ctrl (4 digits, 4-cycle ticks).
module tb_seven_seg_scan_ctrl;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [15:0] data_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  anode;
    logic [3:0]  char;
    logic [1:0]  digit_idx;
    logic        frame_start;
`ifdef BRIGHTNESS_EN
    logic [2:0]  brightness;
`endif

    int errors = 0;
    int checks = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (4),
        .BLANK_TICKS (1),
        .ON_TICKS    (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .data_in     (data_in),
        .load        (load),
`ifdef BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .load_ack    (load_ack),
        .anode       (anode),
        .char        (char),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode: got %h expected %h", anode, 4'hF); end
        checks++; if (char !== 4'h0) begin errors++; $display("FAIL reset_char: got %h expected %h", char, 4'h0); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", load_ack); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_load_idle();
        load    = 1'b1;
        data_in = 16'h1234;
        @(negedge clock);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL idle_ack_pulse: got %b expected 1", load_ack); end
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL idle_anode: got %h expected %h", anode, 4'hF); end
        load = 1'b0;
        @(negedge clock);
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_end: got %b expected 0", load_ack); end
    endtask

    // Cycle c counts negedges after the enabling posedge: 16 cycles per digit, 4 dark then 12 lit.
    task automatic test_scan();
        logic [15:0] frame;
        logic [3:0]  exp_an;
        int          d;
        int          ph;
        frame  = 16'h1234;
        enable = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            d      = (c / 16) % 4;
            ph     = c % 16;
            exp_an = (ph < 4) ? 4'hF : ~(4'b0001 << d);
            checks++; if (anode !== exp_an) begin errors++; $display("FAIL scan_anode c=%0d: got %b expected %b", c, anode, exp_an); end
            checks++; if (digit_idx !== 2'(d)) begin errors++; $display("FAIL scan_idx c=%0d: got %0d expected %0d", c, digit_idx, d); end
            checks++; if (frame_start !== (c == 0)) begin errors++; $display("FAIL scan_fs c=%0d: got %b expected %b", c, frame_start, (c == 0)); end
            if (ph >= 4) begin
                checks++; if (char !== frame[4*d +: 4]) begin errors++; $display("FAIL scan_char c=%0d: got %h expected %h", c, char, frame[4*d +: 4]); end
            end
        end
    endtask

    task automatic test_frame_load();
        logic [15:0] frame;
        logic [3:0]  exp_an;
        int          d;
        int          ph;
        for (int c = 64; c < 160; c++) begin
            @(negedge clock);
            frame  = (c >= 128) ? 16'hABCD : 16'h1234;
            d      = (c / 16) % 4;
            ph     = c % 16;
            exp_an = (ph < 4) ? 4'hF : ~(4'b0001 << d);
            checks++; if (anode !== exp_an) begin errors++; $display("FAIL fl_anode c=%0d: got %b expected %b", c, anode, exp_an); end
            checks++; if (load_ack !== (c == 128)) begin errors++; $display("FAIL fl_ack c=%0d: got %b expected %b", c, load_ack, (c == 128)); end
            checks++; if (frame_start !== (c % 64 == 0)) begin errors++; $display("FAIL fl_fs c=%0d: got %b expected %b", c, frame_start, (c % 64 == 0)); end
            if (ph >= 4) begin
                checks++; if (char !== frame[4*d +: 4]) begin errors++; $display("FAIL fl_char c=%0d: got %h expected %h", c, char, frame[4*d +: 4]); end
            end
            if (c == 84) begin
                load    = 1'b1;
                data_in = 16'hABCD;
            end
            if (c == 128) load = 1'b0;
        end
    endtask

    task automatic test_disable();
        for (int c = 160; c <= 168; c++) @(negedge clock);
        checks++; if (anode !== 4'b1011) begin errors++; $display("FAIL dis_pre_anode: got %b expected 1011", anode); end
        checks++; if (char !== 4'hB) begin errors++; $display("FAIL dis_pre_char: got %h expected b", char); end
        enable = 1'b0;
        @(negedge clock);
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL dis_anode: got %b expected 1111", anode); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL dis_idx: got %0d expected 0", digit_idx); end
        checks++; if (char !== 4'hB) begin errors++; $display("FAIL dis_char_held: got %h expected b", char); end
        @(negedge clock);
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL dis_idle_anode: got %b expected 1111", anode); end
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++; if (anode !== ((k < 4) ? 4'hF : 4'b1110)) begin errors++; $display("FAIL reen_anode k=%0d: got %b expected %b", k, anode, ((k < 4) ? 4'hF : 4'b1110)); end
            checks++; if (frame_start !== (k == 0)) begin errors++; $display("FAIL reen_fs k=%0d: got %b expected %b", k, frame_start, (k == 0)); end
        end
        checks++; if (char !== 4'hD) begin errors++; $display("FAIL reen_char: got %h expected d", char); end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL ares_anode: got %b expected 1111", anode); end
        checks++; if (char !== 4'h0) begin errors++; $display("FAIL ares_char: got %h expected 0", char); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL ares_idx: got %0d expected 0", digit_idx); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++; if (anode !== ((k < 4) ? 4'hF : 4'b1110)) begin errors++; $display("FAIL ares_restart k=%0d: got %b expected %b", k, anode, ((k < 4) ? 4'hF : 4'b1110)); end
        end
        checks++; if (char !== 4'h0) begin errors++; $display("FAIL ares_char_restart: got %h expected 0", char); end
    endtask

    task automatic test_random();
        logic [3:0] prev_anode;
        logic [3:0] prev_char;
        int         dark_run;
        bit         had_lit;
        bit         lit;
        bit         prev_lit;
        prev_anode = anode;
        prev_char  = char;
        prev_lit   = 1'b0;
        had_lit    = 1'b0;
        dark_run   = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            lit = (anode != 4'hF);
            checks++; if ($countones(~anode) > 1) begin errors++; $display("FAIL rnd_onehot c=%0d: got %b expected at most one low", c, anode); end
            if (lit && !prev_lit && had_lit) begin
                checks++; if (dark_run < 4) begin errors++; $display("FAIL rnd_gap c=%0d: got %0d expected >=4", c, dark_run); end
            end
            if (lit && prev_lit) begin
                checks++; if (char !== prev_char || anode !== prev_anode) begin errors++; $display("FAIL rnd_stable c=%0d: got %h/%b expected %h/%b", c, char, anode, prev_char, prev_anode); end
            end
            if (load_ack) begin
                checks++; if (!load) begin errors++; $display("FAIL rnd_ack_noreq c=%0d: got ack expected none", c); end
                if (!frame_start) begin
                    checks++; if (enable) begin errors++; $display("FAIL rnd_ack_midframe c=%0d: got ack expected only at boundary", c); end
                end
            end
            dark_run   = lit ? 0 : dark_run + 1;
            had_lit    = had_lit | lit;
            prev_lit   = lit;
            prev_char  = char;
            prev_anode = anode;
            if (load_ack) load = 1'b0;
            else if (!load && $urandom_range(0, 49) == 0) begin
                load    = 1'b1;
                data_in = 16'($urandom);
            end
            if ($urandom_range(0, 299) == 0) enable = ~enable;
        end
    endtask

`ifdef BRIGHTNESS_EN
    task automatic test_brightness();
        logic [3:0] exp_an;
        load = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            brightness = (pass == 0) ? 3'd3 : 3'd7;
            enable     = 1'b0;
            @(negedge clock);
            @(negedge clock);
            enable = 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clock);
                if (k < 4) exp_an = 4'hF;
                else if (pass == 1 || (k % 4) < 2) exp_an = 4'b1110;
                else exp_an = 4'hF;
                checks++; if (anode !== exp_an) begin errors++; $display("FAIL bright%0d k=%0d: got %b expected %b", pass, k, anode, exp_an); end
            end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        data_in = 16'h0;
`ifdef BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        @(negedge clock);
        test_reset();
        test_load_idle();
        test_scan();
        test_frame_load();
        test_disable();
        test_async_reset();
        test_random();
`ifdef BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
